argmax_stream_ctrl: RTL
=======================

Name: argmax_stream_ctrl

Overview:
- Sequential classifier back end that accepts the NUM_CLASSES output-layer scores one per beat over a valid/ready stream.
- Keeps a running signed maximum and its index, then presents the winning digit index on a held output handshake.
- Sits between the fully-connected layer's serial score output and the top-level result register.
- Replaces the wide parallel comparator chain with one comparator that is reused over NUM_CLASSES cycles.

Parameters:
W, 64, score width in bits (signed two's complement)
NUM_CLASSES, 10, number of scores per classification (range 2..16)
IDX_W, 4, width of the index and beat counter (must satisfy 2**IDX_W >= NUM_CLASSES)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  one-cycle pulse that begins a classification; ignored unless in IDLE
abort  in  1  synchronous abort; returns to IDLE from any state
in_valid  in  1  score beat valid
in_ready  out  1  block can accept a score beat
in_score  in  W  signed score for class index = current beat count
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
max_index  out  IDX_W  index of the winning class
max_value  out  W  signed score of the winning class
busy  out  1  high in ACCUM or DONE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, cnt=0, run_max=0, run_idx=0. All outputs 0: in_ready, out_valid, busy, max_index, max_value.
- States: IDLE, ACCUM, DONE. All registers are updated on the rising edge of clk.
- IDLE:
  - in_ready=0; out_valid=0.
  - start=1 -> ACCUM with cnt=0.
  - The previous max_index and max_value hold until the next accepted beat 0.
- ACCUM:
  - in_ready=1, combinational from state only; it does not depend on in_valid.
  - A beat is accepted when in_valid && in_ready.
  - Beat with cnt=0: run_max=in_score, run_idx=0, unconditionally.
  - Beat with cnt>0: if in_score > run_max (signed, strict), then run_max=in_score and run_idx=cnt. Otherwise hold.
  - Ties keep the earlier index. An all-equal input yields index 0.
  - After each accepted beat, cnt increments.
  - The accepted beat with cnt=NUM_CLASSES-1 moves the state to DONE. The final compare is included in that same edge.
  - in_valid=0 stalls indefinitely with no state change.
- DONE:
  - out_valid=1, in_ready=0; max_index=run_idx, max_value=run_max, stable while out_valid && !out_ready.
  - out_ready=1 -> IDLE on that edge.
  - Latency: out_valid rises the cycle after the last accepted beat.
- start while busy is ignored; no queueing.
- start and out_ready in the same cycle in DONE: complete the handshake to IDLE and drop start.
- abort=1 in any state -> IDLE, cnt=0, out_valid=0 next cycle.
  - abort has priority over start, beat acceptance and out_ready.
  - A beat presented in the abort cycle is not consumed: in_ready is still 1 that cycle, but no register update occurs, and the source must re-issue it.
- rst_n asserted mid-ACCUM or mid-DONE: immediate return to reset values; the partial result is lost.
- Arithmetic: comparison is full-width signed, with no saturation and no truncation. The counter never exceeds NUM_CLASSES-1.
- Throughput: one score per cycle when in_valid stays high. Minimum cycles per classification = 1 (start) + NUM_CLASSES + 1 (DONE with out_ready=1).

Decomposition:
- Shared package cnn_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2;
  - default NUM_CLASSES=10 and SCORE_W=64 shared with the FC layer;
  - IDX_W derivation as a constant function (clog2).
- One natural sub-module: argmax_update_unit.
  - Purely combinational.
  - Inputs: first flag, in_score, cnt, run_max, run_idx.
  - Outputs: next_max, next_idx.
  - Kept separate so it is reused by a future parallel/partial-reduction variant.
- The FSM, counter and handshake stay in argmax_stream_ctrl.

Test Plan:
- Basic: start, then scores 5,-3,12,7,0,1,2,3,4,11 back-to-back, out_ready=1 -> out_valid in the cycle after beat 9, max_index=2, max_value=12, IDLE next cycle.
- Ties and negatives: scores all -8 except index 4=-1 and index 7=-1 -> max_index=4, max_value=-1. All ten equal to 9 -> max_index=0.
- Backpressure: in_valid toggled 1,0,0,1... with random gaps; out_ready held 0 for 5 cycles.
  - Result max_index=9 for an ascending sequence 0..9.
  - out_valid, max_index and max_value stable through the stall.
  - start pulses during DONE are ignored.
- Extremes: index 3 = most positive (2^63-1), index 0 = most negative (-2^63), others 0 -> max_index=3. This proves signed, not unsigned, compare.
- Abort and reset:
  - abort after 4 beats, then a fresh start with scores 0..9 reversed (9..0) -> max_index=0. No contamination from aborted data.
  - rst_n pulsed low mid-ACCUM -> all outputs 0 asynchronously and the state is IDLE.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants for the CNN classifier datapath: state codes, default
// sizes used by the FC layer and the argmax back end, and index-width sizing.
package cnn_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bits needed to hold any value in 0..n-1 (minimum 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/argmax_update_unit.sv
// One step of a running signed argmax: folds a new score into the current
// (max, idx) pair. Strict compare so ties keep the earlier index.
module argmax_update_unit
  import cnn_pkg::*;
#(
  parameter int W     = SCORE_W,
  parameter int IDX_W = 4
) (
  input  logic                    first,
  input  logic signed [W-1:0]     in_score,
  input  logic        [IDX_W-1:0] cnt,
  input  logic signed [W-1:0]     run_max,
  input  logic        [IDX_W-1:0] run_idx,
  output logic signed [W-1:0]     next_max,
  output logic        [IDX_W-1:0] next_idx
);

  always_comb begin
    next_max = run_max;
    next_idx = run_idx;
    if (first) begin
      next_max = in_score;
      next_idx = '0;
    end else if (in_score > run_max) begin
      next_max = in_score;
      next_idx = cnt;
    end
  end

endmodule

// File: rtl/argmax_stream_ctrl.sv
// Serial argmax over NUM_CLASSES streamed scores; one shared comparator,
// result presented on a held valid/ready handshake.
module argmax_stream_ctrl
  import cnn_pkg::*;
#(
  parameter int W           = SCORE_W,
  parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES,
  parameter int IDX_W       = clog2(NUM_CLASSES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W-1:0]     in_score,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [IDX_W-1:0] max_index,
  output logic signed [W-1:0]     max_value,
  output logic                    busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t                  state;
  logic        [IDX_W-1:0] cnt;
  logic signed [W-1:0]     run_max;
  logic        [IDX_W-1:0] run_idx;
  logic signed [W-1:0]     next_max;
  logic        [IDX_W-1:0] next_idx;

  argmax_update_unit #(
    .W     (W),
    .IDX_W (IDX_W)
  ) u_update (
    .first    (cnt == '0),
    .in_score (in_score),
    .cnt      (cnt),
    .run_max  (run_max),
    .run_idx  (run_idx),
    .next_max (next_max),
    .next_idx (next_idx)
  );

  // Handshake flags decode directly from the state register.
  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_ACCUM) || (state == ST_DONE);

  // Result registers double as the outputs, so they hold through IDLE.
  assign max_index = run_idx;
  assign max_value = run_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      run_max <= '0;
      run_idx <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ACCUM;
            cnt   <= '0;
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            run_max <= next_max;
            run_idx <= next_idx;
            if (cnt == LAST_IDX) begin
              state <= ST_DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
